// File: rtl/player_ship.sv
// Player-ship controller: clamped horizontal movement, parallel rocket hit
// detection and the lives / explode / respawn / invulnerable state machine.
module player_ship #(
  parameter int SCREEN_W      = 640,
  parameter int START_X       = 320,
  parameter int SHIP_Y        = 450,
  parameter int STEP          = 2,
  parameter int HALF_W        = 16,
  parameter int HALF_H        = 8,
  parameter int N_ROCKETS     = 4,
  parameter int LIVES         = 3,
  parameter int EXPLODE_TICKS = 60,
  parameter int INVULN_TICKS  = 120
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   playing,
  input  logic                   move_tick,
  input  logic                   left,
  input  logic                   right,
  input  logic [N_ROCKETS-1:0]   rocket_valid,
  input  logic [10*N_ROCKETS-1:0] rocket_x,
  input  logic [9*N_ROCKETS-1:0] rocket_y,
  output logic [9:0]             ship_x,
  output logic [8:0]             ship_y,
  output logic                   ship_hit,
  output logic [N_ROCKETS-1:0]   rocket_clear,
  output logic [3:0]             lives,
  output logic                   visible,
  output logic                   exploding,
  output logic                   game_over
);

  localparam int TMAX  = (EXPLODE_TICKS > INVULN_TICKS) ? EXPLODE_TICKS : INVULN_TICKS;
  // At least 4 bits so the invulnerability blink bit always exists.
  localparam int CNT_W = ($clog2(TMAX + 1) < 4) ? 4 : $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, ALIVE, EXPLODE, INVULN, DEAD} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [N_ROCKETS-1:0] coll;

  function automatic logic [10:0] absdiff11(input logic [10:0] a, input logic [10:0] b);
    logic [10:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return d;
  endfunction

  // Edge-clamped position update; both or neither button holds position.
  function automatic logic [9:0] move_x(input logic [9:0] x, input logic l, input logic r);
    logic [10:0] xe;
    logic [9:0]  nx;
    xe = {1'b0, x};
    nx = x;
    if (l && !r)
      nx = (xe >= 11'(HALF_W + STEP)) ? 10'(xe - 11'(STEP)) : 10'(HALF_W);
    else if (r && !l)
      nx = ((xe + 11'(STEP)) <= 11'(SCREEN_W - HALF_W)) ? 10'(xe + 11'(STEP))
                                                        : 10'(SCREEN_W - HALF_W);
    return nx;
  endfunction

  assign ship_y  = 9'(SHIP_Y);
  assign cnt_inc = cnt + CNT_W'(1);

  always_comb begin
    coll = '0;
    for (int i = 0; i < N_ROCKETS; i++) begin
      coll[i] = rocket_valid[i]
             && (absdiff11({1'b0, rocket_x[10*i +: 10]}, {1'b0, ship_x}) <= 11'(HALF_W))
             && (absdiff11({2'b0, rocket_y[9*i +: 9]}, 11'(SHIP_Y)) <= 11'(HALF_H));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ship_x       <= 10'(START_X);
      lives        <= 4'(LIVES);
      ship_hit     <= 1'b0;
      rocket_clear <= '0;
      visible      <= 1'b1;
      exploding    <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      ship_hit     <= 1'b0;
      rocket_clear <= '0;
      if (!playing) begin
        state     <= IDLE;
        cnt       <= '0;
        ship_x    <= 10'(START_X);
        lives     <= 4'(LIVES);
        visible   <= 1'b1;
        exploding <= 1'b0;
        game_over <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ALIVE;
          ALIVE: begin
            // A hit takes precedence over movement in the same cycle.
            if (|coll) begin
              ship_hit     <= 1'b1;
              rocket_clear <= coll;
              lives        <= lives - 4'd1;
              visible      <= 1'b0;
              cnt          <= '0;
              if (lives == 4'd1) begin
                state     <= DEAD;
                game_over <= 1'b1;
              end else begin
                state     <= EXPLODE;
                exploding <= 1'b1;
              end
            end else if (move_tick) begin
              ship_x <= move_x(ship_x, left, right);
            end
          end
          EXPLODE: begin
            if (move_tick) begin
              if (cnt == CNT_W'(EXPLODE_TICKS - 1)) begin
                state     <= INVULN;
                cnt       <= '0;
                ship_x    <= 10'(START_X);
                exploding <= 1'b0;
                visible   <= 1'b1;
              end else begin
                cnt <= cnt_inc;
              end
            end
          end
          INVULN: begin
            if (move_tick) begin
              ship_x <= move_x(ship_x, left, right);
              if (cnt == CNT_W'(INVULN_TICKS - 1)) begin
                state   <= ALIVE;
                cnt     <= '0;
                visible <= 1'b1;
              end else begin
                cnt     <= cnt_inc;
                visible <= ~cnt_inc[3];
              end
            end
          end
          DEAD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
